debounced_logic_gate: RTL
=========================

// Module: debounced_logic_gate
// PURPOSE
//  N-input logic gate driven by board switches, with a selectable function,
//  an optional invert and a registered LED output. Each switch passes through a
//  2-flop synchroniser and a per-channel debounce counter, so contact bounce
//  never reaches the gate. Output changes are flagged and counted.
//  Sits between the switch pins and the LED pin in the lab top-levels.
// PARAMETERS
//  N_INPUTS        3   number of switch channels (>=2)
//  DEBOUNCE_CYCLES 4   cycles a synchronised input must hold a new value (>=1)
//  CNT_W           8   width of toggle_count
// PORTS
//  clk           in   1        single system clock, all logic on rising edge
//  rst           in   1        synchronous, active-high reset
//  sw            in   N_INPUTS raw asynchronous switch inputs
//  mode          in   3        gate function select (sampled, see below)
//  led           out  1        registered gate output
//  led_changed   out  1        1-cycle pulse when led changes value
//  toggle_count  out  CNT_W    number of led changes since reset, wraps
//  sw_stable     out  N_INPUTS debounced switch values (for observation)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): sync flops, sw_stable, debounce counters,
//   led, led_changed, toggle_count and internal primed flag all clear to 0.
//  Synchroniser: sw -> s1 -> s2, two flops per channel.
//  Debounce per channel i, every cycle:
//   s2[i]==sw_stable[i]          -> cnt[i]<=0
//   s2[i]!=sw_stable[i], cnt[i]<DEBOUNCE_CYCLES-1 -> cnt[i]<=cnt[i]+1
//   s2[i]!=sw_stable[i], cnt[i]==DEBOUNCE_CYCLES-1 -> sw_stable[i]<=s2[i], cnt[i]<=0
//   Any bounce back to the stable value restarts the count from 0.
//   Counter width = $clog2(DEBOUNCE_CYCLES)+1; channels fully independent.
//  Gate function f(sw_stable, mode), mode decoded combinationally each cycle:
//   0 AND  1 NAND  2 OR  3 NOR  4 XOR(parity)  5 XNOR  6,7 -> NAND
//  led <= f(sw_stable, mode) every cycle (one register stage, no enable).
//  Latency: sw step held steady at edge k -> s2 at k+2 -> sw_stable at
//   k+2+DEBOUNCE_CYCLES -> led at k+3+DEBOUNCE_CYCLES. mode change -> led
//   one cycle later (mode is not debounced; it is a synchronous control).
//  primed <= 1 on the first edge after rst deasserts. While primed=0, led
//   loads normally but led_changed stays 0 and toggle_count does not count
//   (suppresses the reset->first-value transition).
//  When primed=1 and the next led value differs from current led:
//   led_changed <= 1 for exactly one cycle; toggle_count <= toggle_count+1,
//   wrapping 2^CNT_W-1 -> 0. Otherwise led_changed <= 0.
//  Simultaneous events: several channels settling the same cycle and a mode
//   change in that cycle form ONE new led value -> at most one pulse/increment.
//   If settling and mode change cancel (same f), no pulse.
//  Reset mid-operation: all state cleared on that edge regardless of in-flight
//   debounce counts; partially debounced inputs are discarded.
// TESTING (N_INPUTS=3, DEBOUNCE_CYCLES=4, CNT_W=8)
//  T1 reset: sw=3'b111, mode=1, rst high 3 cycles -> led=0, count=0,
//   sw_stable=0, no led_changed; after release led=1 with no pulse.
//  T2 truth table: mode=1, sweep sw 000..111, each held 10 cycles -> led=1 for
//   all except 111 ->0; led updates exactly 7 cycles after each sw step.
//  T3 bounce: sw[0] toggles 0/1 every 2 cycles for 20 cycles then holds 1 ->
//   sw_stable[0] changes only 6 cycles after final hold; no earlier change.
//  T4 modes: sw=3'b101 stable, step mode 0..7 one per 3 cycles -> led
//   0,1,1,0,0,1,1,1; led_changed pulses only on value changes.
//  T5 wrap: force 256 led toggles via mode 0/1 alternation on sw=111 ->
//   toggle_count returns to 0, 256 single-cycle pulses.
//  T6 reset mid-debounce: sw 000->111, assert rst 3 cycles later ->
//   sw_stable stays 000, led=0, count=0 after reset.

Source files
------------

// File: rtl/debounced_logic_gate.sv
// debounced_logic_gate: synchronised, debounced N-input gate driving a registered LED with change counting
module debounced_logic_gate #(
  parameter int N_INPUTS = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] sw,
  input  logic [2:0]          mode,
  output logic                led,
  output logic                led_changed,
  output logic [CNT_W-1:0]    toggle_count,
  output logic [N_INPUTS-1:0] sw_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N_INPUTS-1:0] s1_q, s2_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q [N_INPUTS];
  logic [CW-1:0] cnt_d [N_INPUTS];
  logic led_q, led_d, changed_q, changed_d, primed_q, gate;
  logic [CNT_W-1:0] count_q, count_d;
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_INPUTS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  // Modes 1,3,5,6,7 are the inverted forms of AND/OR/XOR
  always_comb begin
    gate = (mode == 3'd2 || mode == 3'd3) ? |stable_q :
           (mode == 3'd4 || mode == 3'd5) ? ^stable_q : &stable_q;
    led_d = (mode == 3'd0 || mode == 3'd2 || mode == 3'd4) ? gate : ~gate;
    changed_d = primed_q && (led_d != led_q);
    count_d = count_q + CNT_W'(changed_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      stable_q <= '0;
      for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= '0;
      led_q <= 1'b0;
      changed_q <= 1'b0;
      count_q <= '0;
      primed_q <= 1'b0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= cnt_d[i];
      led_q <= led_d;
      changed_q <= changed_d;
      count_q <= count_d;
      primed_q <= 1'b1;
    end
  end
  assign led = led_q;
  assign led_changed = changed_q;
  assign toggle_count = count_q;
  assign sw_stable = stable_q;
endmodule
